// File: rtl/barrett_sched_pkg.sv
// Shared constants for the Barrett reduction scheduler: FSM encodings and
// default sizing.
package barrett_sched_pkg;

    localparam int NBITS_DEF = 128;
    localparam int NREQ_DEF  = 4;
    localparam int LAT_DEF   = 3;

    localparam logic [1:0] ST_UNCFG = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

endpackage

// File: rtl/barrett_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward,
// pointer moves to winner+1 after each grant.
module barrett_rr_arb
    import barrett_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] sel;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        sel       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel = IDW'((int'(ptr_q) + i) % NREQ);
            if (en_i && !gnt_vld_o && req_i[sel]) begin
                gnt_vld_o  = 1'b1;
                gnt_id_o   = sel;
                gnt_o[sel] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/barrett_sched.sv
// Front-end scheduler for a fixed-latency Barrett reducer: holds the modulus
// configuration, arbitrates requesters and routes results back by tag.
module barrett_sched
    import barrett_sched_pkg::*;
#(
    parameter  int NBITS = NBITS_DEF,
    parameter  int NREQ  = NREQ_DEF,
    parameter  int LAT   = LAT_DEF,
    localparam int IDW   = $clog2(NREQ),
    localparam int KW    = 2 * $clog2(NBITS),
    localparam int CW    = $clog2(LAT + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NBITS-1:0]        cfg_m,
    input  logic [NBITS+31:0]       cfg_md,
    input  logic [KW-1:0]           cfg_k,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*2*NBITS-1:0] req_a,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [NBITS-1:0]        rsp_y,
    output logic                    red_enable_p,
    output logic [2*NBITS-1:0]      red_a,
    output logic [NBITS-1:0]        red_m,
    output logic [NBITS+31:0]       red_md,
    output logic [KW-1:0]           red_k,
    output logic [NBITS+1:0]        red_mx3,
    input  logic                    red_done,
    input  logic [NBITS-1:0]        red_y,
    output logic                    configured,
    output logic                    busy,
    output logic                    err
);

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] m_q;
    logic [NBITS+31:0] md_q;
    logic [KW-1:0]    k_q;
    logic [NBITS+1:0] mx3_q, mx3_d;
    logic             configured_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q;
    logic [IDW-1:0]   tag_id_q [LAT];
    logic [LAT-1:0]   tag_vld_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             issue;

    barrett_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q == ST_RUN),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (issue)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_UNCFG: if (cfg_valid) state_d = ST_LOAD;
            ST_RUN:   if (cfg_valid) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            default:  state_d = ST_UNCFG;
        endcase
    end

    // 3*m kept at full width so the reducer's final-correction compare never wraps.
    assign mx3_d = {2'b00, cfg_m} + {1'b0, cfg_m, 1'b0};

    always_comb begin
        cnt_d = cnt_q;
        if (issue && !red_done) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!issue && red_done && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNCFG;
            m_q          <= '0;
            md_q         <= '0;
            k_q          <= '0;
            mx3_q        <= '0;
            configured_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_LOAD) begin
                m_q          <= cfg_m;
                md_q         <= cfg_md;
                k_q          <= cfg_k;
                mx3_q        <= mx3_d;
                configured_q <= 1'b1;
            end
            if (red_done != tag_vld_q[LAT-1]) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag line mirrors the reducer pipeline so the owner id emerges with red_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_comb begin
        red_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                red_a = req_a[i*2*NBITS +: 2*NBITS];
            end
        end
    end

    assign cfg_ready    = (state_q == ST_UNCFG) || (state_q == ST_LOAD);
    assign req_ready    = gnt;
    assign red_enable_p = issue;
    assign red_m        = m_q;
    assign red_md       = md_q;
    assign red_k        = k_q;
    assign red_mx3      = mx3_q;
    assign rsp_valid    = red_done;
    assign rsp_id       = tag_id_q[LAT-1];
    assign rsp_y        = red_y;
    assign configured   = configured_q;
    assign busy         = (cnt_q != '0);
    assign err          = err_q;

endmodule

// File: doc/barrett_sched.md
BARRETT_SCHED -- requirements
Module: barrett_sched

Interface
REQ-001 Parameter NBITS, default 128, operand modulus width.
REQ-002 Parameter NREQ, default 4, number of requesters; IDW = $clog2(NREQ).
REQ-003 Parameter LAT, default 3, reducer issue-to-done latency in cycles.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  config handshake.
REQ-007 cfg_m / cfg_md / cfg_k  in  NBITS / NBITS+32 / 2*$clog2(NBITS)  modulus, Barrett constant, shift.
REQ-008 req_valid / req_ready  in / out  NREQ / NREQ  per-requester handshake.
REQ-009 req_a  in  NREQ*2*NBITS  packed operands; requester i uses slice i.
REQ-010 rsp_valid / rsp_id / rsp_y  out  1 / IDW / NBITS  result pulse, owner index, reduced value.
REQ-011 red_enable_p  out  1  issue pulse to the Barrett reducer.
REQ-012 red_a / red_m / red_md / red_k / red_mx3  out  2*NBITS / NBITS / NBITS+32 / 2*$clog2(NBITS) / NBITS+2  reducer operands.
REQ-013 red_done / red_y  in  1 / NBITS  reducer completion and result.
REQ-014 configured / busy / err  out  1 each  status; busy = any op in flight.

Function
REQ-015 FSM states UNCFG, RUN, DRAIN, LOAD; UNCFG after reset.
REQ-016 UNCFG: cfg_ready=1, no grants; cfg_valid -> LOAD.
REQ-017 RUN: cfg_valid -> DRAIN; grants continue only in RUN.
REQ-018 DRAIN: no grants, cfg_ready=0; when in-flight count is 0 -> LOAD.
REQ-019 LOAD: one cycle, cfg_ready=1, capture m, md, k; mx3 register = 3*m (NBITS+2 bits, no truncation); configured=1; -> RUN.
REQ-020 cfg handshake completes only in LOAD, or in UNCFG the cycle cfg_valid is seen (then LOAD captures); cfg values held stable by source until cfg_ready.
REQ-021 Arbitration: round-robin over req_valid starting at pointer; at most one grant per cycle.
REQ-022 Pointer advances to winner+1 mod NREQ after a grant; unchanged otherwise.
REQ-023 req_ready[i]=1 only for the granted index in that cycle (combinational from req_valid, state, pointer).
REQ-024 Grant cycle: red_enable_p=1, red_a = winner slice; red_m/md/k/mx3 always driven from config registers.
REQ-025 Issue pipelined back-to-back; throughput one op/cycle.
REQ-026 Owner id pushed into LAT-deep tag shift line with valid bit on issue.
REQ-027 red_done in cycle c+LAT for issue in cycle c; rsp_valid=1, rsp_id = tag line output, rsp_y = red_y, same cycle (combinational pass-through, zero added latency).
REQ-028 In-flight counter: +1 on issue, -1 on red_done, simultaneous -> unchanged; width $clog2(LAT+1)+1.
REQ-029 red_done with tag-line valid=0, or tag valid with red_done=0 -> err sticky 1 until reset; rsp_valid still follows red_done.
REQ-030 No response backpressure; requesters always accept rsp_valid.
REQ-031 cfg_valid simultaneous with a grant in RUN: the grant is issued, FSM enters DRAIN next cycle.

Reset
REQ-032 rst_n low: state UNCFG, pointer 0, in-flight 0, tag line cleared, config registers 0, mx3 0, configured 0, err 0.
REQ-033 Outputs during/after reset: red_enable_p 0, req_ready 0, rsp_valid 0 only if red_done 0, cfg_ready 1.
REQ-034 Reset mid-operation discards all in-flight tags; no rsp_id is generated for ops issued before reset.

Structure
REQ-035 Shared package holds FSM state enum, default NBITS/NREQ/LAT constants.
REQ-036 One sub-module: barrett_rr_arb (NREQ-wide round-robin arbiter: valid in, one-hot grant, pointer update).
REQ-037 Reducer instantiated by the parent; this block only drives/receives its ports.

Verification
REQ-038 Reset, cfg m=97, md=floor(2^14/97)=168, k=7 -> configured=1 after LOAD, red_mx3=291.
REQ-039 Requester 2 sends a=10000 -> red_enable_p one cycle, red_a=10000; model reducer returns 9 at +3 -> rsp_valid, rsp_id=2, rsp_y=9.
REQ-040 All 4 requesters valid continuously 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_ids in same order, each 3 cycles after issue.
REQ-041 cfg_valid while 3 ops in flight -> no grants in DRAIN, all 3 responses delivered, then LOAD, new m visible on red_m.
REQ-042 Inject spurious red_done with empty tag line -> err=1, stays 1 until rst_n low.
REQ-043 Assert rst_n low with 2 ops in flight -> counter 0, state UNCFG, req_ready all 0 until reconfigured.
